// File: rtl/red_pitaya_asg_outramp_pkg.sv
`default_nettype none
// ============================================================================
// red_pitaya_asg_outramp_pkg
// Shared widths, ramp state encodings and unity-gain helper for the
// ASG output ramp stage.
// Revision: 1.0
// ============================================================================
package red_pitaya_asg_outramp_pkg;

    localparam int c_DW_DEF = 14;
    localparam int c_GW_DEF = 16;

    localparam logic [1:0] c_ST_OFF  = 2'd0;
    localparam logic [1:0] c_ST_UP   = 2'd1;
    localparam logic [1:0] c_ST_ON   = 2'd2;
    localparam logic [1:0] c_ST_DOWN = 2'd3;

    function automatic int unsigned f_unity_gain(input int unsigned gw);
        return 32'd1 << (gw - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/red_pitaya_asg_outramp_if.sv
`default_nettype none
// ============================================================================
// red_pitaya_asg_outramp_if
// Sample, control and status bundle between an ASG channel and its ramp stage.
// Revision: 1.0
// ============================================================================
interface red_pitaya_asg_outramp_if #(
    parameter int DW = 14,
    parameter int GW = 16
);
    logic signed [DW-1:0] dat_i;
    logic                 enable_i;
    logic [GW-1:0]        ramp_step_i;
    logic [15:0]          ramp_div_i;
    logic [DW-2:0]        slew_max_i;
    logic signed [DW-1:0] dac_o;
    logic [1:0]           state_o;
    logic                 busy_o;
    logic [GW:0]          gain_o;

    modport slave (
        input  dat_i, enable_i, ramp_step_i, ramp_div_i, slew_max_i,
        output dac_o, state_o, busy_o, gain_o
    );

    modport master (
        output dat_i, enable_i, ramp_step_i, ramp_div_i, slew_max_i,
        input  dac_o, state_o, busy_o, gain_o
    );
endinterface
`default_nettype wire

// File: rtl/red_pitaya_slew_lim.sv
`default_nettype none
// ============================================================================
// red_pitaya_slew_lim
// Registered per-cycle slew-rate limiter; slew_max of zero passes the target.
// Revision: 1.0
// ============================================================================
module red_pitaya_slew_lim
    import red_pitaya_asg_outramp_pkg::*;
#(
    parameter int DW = c_DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] target,
    input  logic [DW-2:0]        slew_max,
    output logic signed [DW-1:0] out
);
    logic signed [DW:0]   w_diff;
    logic signed [DW:0]   w_lim;
    logic signed [DW-1:0] w_step;
    logic signed [DW-1:0] w_next;

    assign w_diff = {target[DW-1], target} - {out[DW-1], out};
    assign w_lim  = {2'b00, slew_max};
    assign w_step = {1'b0, slew_max};

    // Any limited result lies between the old output and the target, so no wrap.
    always_comb begin
        w_next = target;
        if (slew_max != '0) begin
            if (w_diff > w_lim)
                w_next = out + w_step;
            else if (w_diff < -w_lim)
                w_next = out - w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            out <= '0;
        else
            out <= w_next;
    end

endmodule
`default_nettype wire

// File: rtl/red_pitaya_asg_outramp.sv
`default_nettype none
// ============================================================================
// red_pitaya_asg_outramp
// Soft-start/soft-stop gain ramp and slew limiter on one ASG DAC channel.
// Revision: 1.0
// ============================================================================
module red_pitaya_asg_outramp
    import red_pitaya_asg_outramp_pkg::*;
#(
    parameter int DW = c_DW_DEF,
    parameter int GW = c_GW_DEF
) (
    input  logic                    dac_clk_i,
    input  logic                    dac_rst_i,
    red_pitaya_asg_outramp_if.slave bus
);
    localparam logic [GW:0] c_G1 = (GW+1)'(f_unity_gain(GW));

    logic [1:0]           r_state;
    logic                 r_busy;
    logic [GW:0]          r_gain;
    logic [15:0]          r_cnt;
    logic signed [DW-1:0] r_d1;
    logic signed [DW-1:0] r_s2;

    logic [1:0]           w_state_nxt;
    logic [GW:0]          w_gain_nxt;
    logic [15:0]          w_cnt_nxt;
    logic                 w_busy_nxt;
    logic                 w_tick;
    logic                 w_instant;
    logic [GW+1:0]        w_sum;
    logic signed [GW+1:0] w_dif;
    logic [GW:0]          w_up_gain;
    logic [GW:0]          w_dn_gain;
    logic signed [DW+GW:0] w_a;
    logic signed [DW+GW:0] w_b;
    logic signed [DW+GW:0] w_prod;
    logic                 w_unused_prod;
    logic signed [DW-1:0] w_dac;

    assign w_tick    = (r_cnt == bus.ramp_div_i);
    assign w_instant = (bus.ramp_step_i == '0);
    assign w_sum     = {1'b0, r_gain} + {2'b00, bus.ramp_step_i};
    assign w_dif     = $signed({1'b0, r_gain}) - $signed({2'b00, bus.ramp_step_i});
    assign w_up_gain = (w_instant || (w_sum >= {1'b0, c_G1})) ? c_G1 : w_sum[GW:0];
    assign w_dn_gain = (w_instant || w_dif[GW+1] || (w_dif == '0)) ? '0 : w_dif[GW:0];

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            r_state <= c_ST_OFF;
            r_busy  <= 1'b0;
            r_gain  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_gain  <= w_gain_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A direction change takes priority over a coincident tick.
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        case (r_state)
            c_ST_OFF: begin
                if (bus.enable_i)
                    w_state_nxt = c_ST_UP;
            end
            c_ST_UP: begin
                if (!bus.enable_i) begin
                    w_state_nxt = c_ST_DOWN;
                end else if (w_instant || w_tick) begin
                    w_gain_nxt = w_up_gain;
                    if (w_up_gain == c_G1)
                        w_state_nxt = c_ST_ON;
                end
            end
            c_ST_ON: begin
                if (!bus.enable_i)
                    w_state_nxt = c_ST_DOWN;
            end
            default: begin
                if (bus.enable_i) begin
                    w_state_nxt = c_ST_UP;
                end else if (w_instant || w_tick) begin
                    w_gain_nxt = w_dn_gain;
                    if (w_dn_gain == '0)
                        w_state_nxt = c_ST_OFF;
                end
            end
        endcase
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt == c_ST_UP) || (w_state_nxt == c_ST_DOWN);
        w_cnt_nxt  = r_cnt + 16'd1;
        if ((w_state_nxt != r_state) || w_tick || (r_cnt > bus.ramp_div_i))
            w_cnt_nxt = '0;
    end

    // Gain never exceeds unity, so the floor-shifted product always fits DW bits.
    assign w_a           = {{(GW+1){r_d1[DW-1]}}, r_d1};
    assign w_b           = {{DW{1'b0}}, r_gain};
    assign w_prod        = w_a * w_b;
    assign w_unused_prod = ^{w_prod[DW+GW:DW+GW-1], w_prod[GW-2:0]};

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            r_d1 <= '0;
            r_s2 <= '0;
        end else begin
            r_d1 <= bus.dat_i;
            r_s2 <= w_prod[DW+GW-2:GW-1];
        end
    end

    red_pitaya_slew_lim #(.DW(DW)) u_slew_lim (
        .clk      (dac_clk_i),
        .rst      (dac_rst_i),
        .target   (r_s2),
        .slew_max (bus.slew_max_i),
        .out      (w_dac)
    );

    assign bus.dac_o   = w_dac;
    assign bus.state_o = r_state;
    assign bus.busy_o  = r_busy;
    assign bus.gain_o  = r_gain;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_asg_outramp.sv
`default_nettype none
// ============================================================================
// tb_red_pitaya_asg_outramp
// Directed phase table plus randomized stimulus against a cycle reference model.
// Revision: 1.0
// ============================================================================
module tb_red_pitaya_asg_outramp;

    localparam int DW = 14;
    localparam int GW = 16;
    localparam int G1 = 32768;

    typedef struct {
        bit rst;
        bit en;
        int step;
        int div;
        int slew;
        int dat;
        int cyc;
        int e_state;
        int e_gain;
        int e_dac;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    red_pitaya_asg_outramp_if #(.DW(DW), .GW(GW)) bus ();

    red_pitaya_asg_outramp #(.DW(DW), .GW(GW)) dut (
        .dac_clk_i (clk),
        .dac_rst_i (rst),
        .bus       (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    bit in_rst, in_en;
    int in_step, in_div, in_slew, in_dat;

    int m_st, m_g, m_cnt, m_d1, m_s2, m_dac;

    vec_t tbl[$];

    task automatic add(input bit r, input bit en, input int step, input int div,
                       input int slew, input int dat, input int cyc,
                       input int es, input int eg, input int ed);
        vec_t v;
        v.rst = r; v.en = en; v.step = step; v.div = div; v.slew = slew;
        v.dat = dat; v.cyc = cyc; v.e_state = es; v.e_gain = eg; v.e_dac = ed;
        tbl.push_back(v);
    endtask

    task automatic drive();
        logic [31:0] t;
        rst = in_rst;
        bus.enable_i = in_en;
        t = in_step; bus.ramp_step_i = t[GW-1:0];
        t = in_div;  bus.ramp_div_i  = t[15:0];
        t = in_slew; bus.slew_max_i  = t[DW-2:0];
        t = in_dat;  bus.dat_i       = t[DW-1:0];
    endtask

    function automatic int floor_div(input int p, input int d);
        int q;
        q = p / d;
        if (p < 0 && (p % d) != 0) q = q - 1;
        return q;
    endfunction

    // Reference behaviour: ramp gain in whole numbers, then scale, then limit.
    task automatic model_step();
        int ns, ng, nd, diff;
        bit tk;
        if (in_rst) begin
            m_st = 0; m_g = 0; m_cnt = 0; m_d1 = 0; m_s2 = 0; m_dac = 0;
            return;
        end
        tk = (m_cnt == in_div);
        ns = m_st;
        ng = m_g;
        if (m_st == 0 && in_en) ns = 1;
        else if (m_st == 2 && !in_en) ns = 3;
        else if (m_st == 1) begin
            if (!in_en) ns = 3;
            else if (in_step == 0 || tk) begin
                ng = (in_step == 0) ? G1 : ((m_g + in_step > G1) ? G1 : m_g + in_step);
                if (ng == G1) ns = 2;
            end
        end else if (m_st == 3) begin
            if (in_en) ns = 1;
            else if (in_step == 0 || tk) begin
                ng = (in_step == 0) ? 0 : ((m_g - in_step < 0) ? 0 : m_g - in_step);
                if (ng == 0) ns = 0;
            end
        end
        diff = m_s2 - m_dac;
        if (in_slew != 0 && diff > in_slew)       nd = m_dac + in_slew;
        else if (in_slew != 0 && diff < -in_slew) nd = m_dac - in_slew;
        else                                      nd = m_s2;
        m_cnt = (ns != m_st || tk || m_cnt > in_div) ? 0 : m_cnt + 1;
        m_dac = nd;
        m_s2  = floor_div(m_d1 * m_g, G1);
        m_d1  = in_dat;
        m_st  = ns;
        m_g   = ng;
    endtask

    task automatic cycle_check();
        bit m_busy;
        @(posedge clk);
        model_step();
        #1;
        m_busy = (m_st == 1 || m_st == 3);
        n_vec++;
        if (bus.dac_o !== 14'(m_dac) || bus.state_o !== 2'(m_st) ||
            bus.gain_o !== 17'(m_g) || bus.busy_o !== m_busy) begin
            n_err++;
            $display("FAIL model t=%0t: dac=%0d want %0d, state=%0d want %0d, gain=%h want %h, busy=%0b want %0b",
                     $time, $signed(bus.dac_o), m_dac, bus.state_o, m_st,
                     bus.gain_o, 17'(m_g), bus.busy_o, m_busy);
        end
    endtask

    initial begin
        bit e_busy;
        add(1, 0, 'h800,  0, 0,     0,     2, 0, 0,      0);
        add(0, 1, 'h800,  0, 0,     'h1000, 17, 2, 'h8000, 'hE00);
        add(0, 1, 'h800,  0, 0,     'h1000, 2, 2, 'h8000, 'h1000);
        add(0, 1, 'h800,  0, 0,     -8192, 3, 2, 'h8000, -8192);
        add(0, 0, 'h8000, 3, 0,     -8192, 4, 3, 'h8000, -8192);
        add(0, 0, 'h8000, 3, 0,     -8192, 1, 0, 0,      -8192);
        add(0, 0, 'h8000, 3, 0,     -8192, 2, 0, 0,      0);
        add(0, 1, 'h1000, 0, 0,     'h1000, 4, 1, 'h3000, 'h200);
        add(0, 0, 'h1000, 0, 0,     'h1000, 1, 3, 'h3000, 'h400);
        add(0, 0, 'h1000, 0, 0,     'h1000, 2, 3, 'h1000, 'h600);
        add(0, 1, 'h1000, 0, 0,     'h1000, 1, 1, 'h1000, 'h400);
        add(0, 1, 'h1000, 0, 0,     'h1000, 1, 1, 'h2000, 'h200);
        add(0, 1, 'h1000, 0, 0,     'h1000, 6, 2, 'h8000, 'hC00);
        add(0, 0, 0,      0, 0,     'h1000, 1, 3, 'h8000, 'hE00);
        add(0, 0, 0,      0, 0,     'h1000, 1, 0, 0,      'h1000);
        add(0, 1, 0,      0, 0,     'h1000, 1, 1, 0,      'h1000);
        add(0, 1, 0,      0, 0,     'h1000, 1, 2, 'h8000, 0);
        add(0, 1, 0,      0, 0,     'h1000, 2, 2, 'h8000, 'h1000);
        add(0, 1, 0,      0, 0,     0,     3, 2, 'h8000, 0);
        add(0, 1, 0,      0, 'h100, 'h1000, 10, 2, 'h8000, 'h800);
        add(0, 1, 0,      0, 'h100, 'h1000, 8, 2, 'h8000, 'h1000);
        add(0, 1, 0,      0, 'h100, 'h1000, 2, 2, 'h8000, 'h1000);
        add(0, 1, 0,      0, 'h100, -4096, 20, 2, 'h8000, -512);
        add(0, 1, 0,      0, 'h100, -4096, 14, 2, 'h8000, -4096);
        add(0, 1, 0,      0, 0,     'h1000, 2, 2, 'h8000, -4096);
        add(0, 1, 0,      0, 0,     'h1000, 1, 2, 'h8000, 'h1000);
        add(0, 0, 0,      0, 0,     'h1000, 4, 0, 0,      0);
        add(0, 1, 'h800,  0, 0,     'h1000, 11, 1, 'h5000, 'h800);
        add(1, 1, 'h800,  0, 0,     'h1000, 1, 0, 0,      0);
        add(0, 1, 'h800,  0, 0,     'h1000, 1, 1, 0,      0);

        for (int i = 0; i < tbl.size(); i++) begin
            in_rst = tbl[i].rst; in_en = tbl[i].en; in_step = tbl[i].step;
            in_div = tbl[i].div; in_slew = tbl[i].slew; in_dat = tbl[i].dat;
            drive();
            for (int c = 0; c < tbl[i].cyc; c++) cycle_check();
            e_busy = (tbl[i].e_state == 1 || tbl[i].e_state == 3);
            n_vec++;
            if (bus.state_o !== 2'(tbl[i].e_state) || bus.gain_o !== 17'(tbl[i].e_gain) ||
                bus.dac_o !== 14'(tbl[i].e_dac) || bus.busy_o !== e_busy) begin
                n_err++;
                $display("FAIL phase %0d: state=%0d want %0d, gain=%h want %h, dac=%0d want %0d, busy=%0b want %0b",
                         i, bus.state_o, tbl[i].e_state, bus.gain_o, 17'(tbl[i].e_gain),
                         $signed(bus.dac_o), tbl[i].e_dac, bus.busy_o, e_busy);
            end
        end

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) in_en = ~in_en;
            if ($urandom_range(0, 49) == 0)
                in_step = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 65535));
            else if ($urandom_range(0, 49) == 0)
                in_step = int'($urandom_range(1, 4096));
            if ($urandom_range(0, 29) == 0) in_div = int'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0)
                in_slew = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 8191));
            in_dat = int'($urandom_range(0, 16383)) - 8192;
            in_rst = ($urandom_range(0, 599) == 0);
            drive();
            cycle_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
